// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multi-cycle RV32I core, driving the shared datapath each cycle.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Z,
  output logic [2:0] ALU_control,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       illegal_instr
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [2:0] ADD_CTRL = 3'b000;
  localparam logic [2:0] SUB_CTRL = 3'b001;
  localparam logic [2:0] AND_CTRL = 3'b010;
  localparam logic [2:0] OR_CTRL  = 3'b011;
  localparam logic [2:0] SLT_CTRL = 3'b101;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;
  state_t r_state, w_next;
  logic       w_funct_ok;
  logic [2:0] w_funct_alu;
  logic [2:0] w_alu;
  logic [1:0] w_sa, w_sb, w_rs;
  logic       w_adr, w_ir, w_rw, w_mw, w_pcu, w_br;
  assign w_funct_ok = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
  // funct7b5 selects sub only for register-register ops; addi ignores it
  assign w_funct_alu = funct3 == 3'b010 ? SLT_CTRL :
                       funct3 == 3'b110 ? OR_CTRL  :
                       funct3 == 3'b111 ? AND_CTRL :
                       (r_state == EXECUTER && funct7b5) ? SUB_CTRL : ADD_CTRL;
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE:
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_R:         w_next = w_funct_ok ? EXECUTER : FETCH;
          OP_I:         w_next = w_funct_ok ? EXECUTEI : FETCH;
          OP_JAL:       w_next = JAL;
          OP_BEQ:       w_next = BEQ;
          default:      w_next = FETCH;
        endcase
      MEMADR:                  w_next = op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:                 w_next = MEMWB;
      EXECUTER, EXECUTEI, JAL: w_next = ALUWB;
      default:                 w_next = FETCH;
    endcase
  end
  always_ff @(posedge clk) r_state <= reset ? FETCH : w_next;
  always_comb begin
    w_alu = ADD_CTRL;
    w_sa  = 2'b00;
    w_sb  = 2'b00;
    w_rs  = 2'b00;
    w_adr = 1'b0;
    w_ir  = 1'b0;
    w_rw  = 1'b0;
    w_mw  = 1'b0;
    w_pcu = 1'b0;
    w_br  = 1'b0;
    case (r_state)
      FETCH:    begin w_sb = 2'b10; w_rs = 2'b10; w_ir = 1'b1; w_pcu = 1'b1; end
      DECODE:   begin w_sa = 2'b01; w_sb = 2'b01; end
      MEMADR:   begin w_sa = 2'b10; w_sb = 2'b01; end
      MEMREAD:  w_adr = 1'b1;
      MEMWB:    begin w_rs = 2'b01; w_rw = 1'b1; end
      MEMWRITE: begin w_adr = 1'b1; w_mw = 1'b1; end
      EXECUTER: begin w_sa = 2'b10; w_alu = w_funct_alu; end
      EXECUTEI: begin w_sa = 2'b10; w_sb = 2'b01; w_alu = w_funct_alu; end
      ALUWB:    w_rw = 1'b1;
      BEQ:      begin w_sa = 2'b10; w_alu = SUB_CTRL; w_br = 1'b1; end
      JAL:      begin w_sa = 2'b01; w_sb = 2'b10; w_pcu = 1'b1; end
      default:  w_alu = ADD_CTRL;
    endcase
  end
  assign ALU_control   = reset ? ADD_CTRL : w_alu;
  assign ALUSrcA       = reset ? 2'b00 : w_sa;
  assign ALUSrcB       = reset ? 2'b00 : w_sb;
  assign ResultSrc     = reset ? 2'b00 : w_rs;
  assign AdrSrc        = !reset && w_adr;
  assign IRWrite       = !reset && w_ir;
  assign RegWrite      = !reset && w_rw;
  assign MemWrite      = !reset && w_mw;
  assign PCWrite       = !reset && (w_pcu || (w_br && Z));
  // an unsupported op/funct3 is exactly a DECODE that falls straight back to FETCH
  assign illegal_instr = !reset && r_state == DECODE && w_next == FETCH;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle vectors; expectations queued by stimulus, checked by a negedge monitor.
module tb_multicycle_control;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b1111111;
  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011, SLT = 3'b101;
  // field order: alu, srcA, srcB, resultSrc, {adr, ir, rw, mw, pw, ill}
  localparam logic [14:0] S_RST     = 15'd0;
  localparam logic [14:0] S_FETCH   = {ADD, 2'b00, 2'b10, 2'b10, 6'b010010};
  localparam logic [14:0] S_DEC     = {ADD, 2'b01, 2'b01, 2'b00, 6'b000000};
  localparam logic [14:0] S_DEC_ILL = {ADD, 2'b01, 2'b01, 2'b00, 6'b000001};
  localparam logic [14:0] S_MEMADR  = {ADD, 2'b10, 2'b01, 2'b00, 6'b000000};
  localparam logic [14:0] S_MEMREAD = {ADD, 2'b00, 2'b00, 2'b00, 6'b100000};
  localparam logic [14:0] S_MEMWB   = {ADD, 2'b00, 2'b00, 2'b01, 6'b001000};
  localparam logic [14:0] S_MEMWR   = {ADD, 2'b00, 2'b00, 2'b00, 6'b100100};
  localparam logic [14:0] S_ALUWB   = {ADD, 2'b00, 2'b00, 2'b00, 6'b001000};
  localparam logic [14:0] S_BEQ_T   = {SUB, 2'b10, 2'b00, 2'b00, 6'b000010};
  localparam logic [14:0] S_BEQ_N   = {SUB, 2'b10, 2'b00, 2'b00, 6'b000000};
  localparam logic [14:0] S_JAL     = {ADD, 2'b01, 2'b10, 2'b00, 6'b000010};
  typedef struct {
    string       name;
    logic [14:0] v;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0;
  logic clk = 1'b0, reset = 1'b1, funct7b5 = 1'b0, Z = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [2:0] ALU_control;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal_instr;
  logic [14:0] act;
  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
    .ALU_control(ALU_control), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .illegal_instr(illegal_instr)
  );
  always #5 clk = ~clk;
  assign act = {ALU_control, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite, PCWrite, illegal_instr};
  function automatic logic [14:0] exr(input logic [2:0] a);
    return {a, 2'b10, 2'b00, 2'b00, 6'b000000};
  endfunction
  function automatic logic [14:0] exi(input logic [2:0] a);
    return {a, 2'b10, 2'b01, 2'b00, 6'b000000};
  endfunction
  always @(negedge clk)
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  task automatic cyc(input string nm, input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [14:0] ev);
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; Z = z;
    q.push_back('{nm, ev});
    @(posedge clk);
    #1;
  endtask
  task automatic rtype(input string nm, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [14:0] ex);
    cyc({nm, "_fetch"}, 0, o, f3, f7, 1, S_FETCH);
    cyc({nm, "_dec"}, 0, o, f3, f7, 1, S_DEC);
    cyc({nm, "_exec"}, 0, o, f3, f7, 1, ex);
    cyc({nm, "_wb"}, 0, o, f3, f7, 1, S_ALUWB);
  endtask
  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset_hold", 1, SW, 3'b010, 0, 1, S_RST);
    cyc("lw_fetch", 0, LW, 3'b010, 0, 1, S_FETCH);
    cyc("lw_dec", 0, LW, 3'b010, 0, 1, S_DEC);
    cyc("lw_memadr", 0, LW, 3'b010, 0, 1, S_MEMADR);
    cyc("lw_memread", 0, LW, 3'b010, 0, 1, S_MEMREAD);
    cyc("lw_memwb", 0, LW, 3'b010, 0, 1, S_MEMWB);
    rtype("sub", RT, 3'b000, 1, exr(SUB));
    rtype("addi_f7", IT, 3'b000, 1, exi(ADD));
    rtype("add", RT, 3'b000, 0, exr(ADD));
    rtype("or", RT, 3'b110, 0, exr(OR));
    rtype("and", RT, 3'b111, 1, exr(AND));
    rtype("slti", IT, 3'b010, 0, exi(SLT));
    rtype("andi", IT, 3'b111, 0, exi(AND));
    cyc("beqT_fetch", 0, BQ, 3'b000, 0, 0, S_FETCH);
    cyc("beqT_dec", 0, BQ, 3'b000, 0, 0, S_DEC);
    cyc("beqT_beq", 0, BQ, 3'b000, 0, 1, S_BEQ_T);
    cyc("beqN_fetch", 0, BQ, 3'b000, 0, 1, S_FETCH);
    cyc("beqN_dec", 0, BQ, 3'b000, 0, 1, S_DEC);
    cyc("beqN_beq", 0, BQ, 3'b000, 0, 0, S_BEQ_N);
    cyc("jal_fetch", 0, JL, 3'b000, 0, 0, S_FETCH);
    cyc("jal_dec", 0, JL, 3'b000, 0, 0, S_DEC);
    cyc("jal_jal", 0, JL, 3'b000, 0, 0, S_JAL);
    cyc("jal_wb", 0, JL, 3'b000, 0, 1, S_ALUWB);
    cyc("sw_fetch", 0, SW, 3'b010, 0, 1, S_FETCH);
    cyc("sw_dec", 0, SW, 3'b010, 0, 1, S_DEC);
    cyc("sw_memadr", 0, SW, 3'b010, 0, 1, S_MEMADR);
    cyc("sw_memwr", 0, SW, 3'b010, 0, 1, S_MEMWR);
    cyc("badop_fetch", 0, BAD, 3'b000, 0, 0, S_FETCH);
    cyc("badop_dec", 0, BAD, 3'b000, 0, 0, S_DEC_ILL);
    cyc("badr_fetch", 0, RT, 3'b001, 0, 0, S_FETCH);
    cyc("badr_dec", 0, RT, 3'b001, 0, 0, S_DEC_ILL);
    cyc("badi_fetch", 0, IT, 3'b100, 0, 0, S_FETCH);
    cyc("badi_dec", 0, IT, 3'b100, 0, 0, S_DEC_ILL);
    cyc("abort_fetch", 0, SW, 3'b010, 0, 0, S_FETCH);
    cyc("abort_dec", 0, SW, 3'b010, 0, 0, S_DEC);
    cyc("abort_memadr", 0, SW, 3'b010, 0, 0, S_MEMADR);
    cyc("abort_memwr_rst", 1, SW, 3'b010, 0, 1, S_RST);
    cyc("post_abort_fetch", 0, SW, 3'b010, 0, 0, S_FETCH);
    cyc("post_abort_dec", 0, SW, 3'b010, 0, 0, S_DEC);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
